// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller: FSM states, per-bank
// strobe phases and the default bus geometry.
package sram_ctrl_pkg;

  localparam int RAM_ADDR_W   = 20;
  localparam int RAM_DATA_W   = 32;
  localparam int BANK_SEL_BIT = 22;
  localparam int LANE_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RMW_RD  = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_HOLD = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_READ  = 2'd1,
    PH_WRITE = 2'd2,
    PH_HOLD  = 2'd3
  } phase_e;

  // Strobe pattern a bank needs while the controller sits in a given state.
  function automatic phase_e state_phase(input state_e s);
    phase_e p;
    case (s)
      ST_RD, ST_RMW_RD: p = PH_READ;
      ST_WR:            p = PH_WRITE;
      ST_WR_HOLD:       p = PH_HOLD;
      default:          p = PH_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side single-word request bus of the SRAM controller.
interface sram_ctrl_if #(
  parameter int DATA_W = 32
);

  localparam int SEL_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;

  modport master (output req, we, addr, sel, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack, busy);

endinterface

// File: rtl/sram_port_drv.sv
// Pin driver for one asynchronous SRAM bank: registers ce/oe/we, address and
// the tri-state data buffer from the next-cycle phase chosen by the FSM.
module sram_port_drv
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  phase_e            phase,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wword,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_oe,
  output logic              ram_we,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] rd_word
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic              drive_q, drive_d;

  // Address and write word only move while this bank is selected, so an idle
  // bank keeps presenting its last address.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    ce_d    = 1'b1;
    oe_d    = 1'b1;
    we_d    = 1'b1;
    drive_d = 1'b0;
    if (enable) begin
      addr_d = address;
      case (phase)
        PH_READ: begin
          ce_d = 1'b0;
          oe_d = 1'b0;
        end
        PH_WRITE: begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          drive_d = 1'b1;
          data_d  = wword;
        end
        PH_HOLD: begin
          ce_d    = 1'b0;
          drive_d = 1'b1;
          data_d  = wword;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drive_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drive_q <= drive_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_ce   = ce_q;
  assign ram_oe   = oe_q;
  assign ram_we   = we_q;
  assign ram_data = drive_q ? data_q : {DATA_W{1'bz}};
  assign rd_word  = ram_data;

endmodule

// File: rtl/sram_ctrl.sv
// Turns single-word CPU requests into strobe sequences on two async SRAM
// banks; partial writes go through a read-modify-write pass.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = RAM_ADDR_W,
  parameter int DATA_W   = RAM_DATA_W,
  parameter int BANK_BIT = BANK_SEL_BIT
) (
  input  logic              clk,
  input  logic              rst,
  sram_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] base_ram_addr,
  output logic              base_ram_ce,
  output logic              base_ram_oe,
  output logic              base_ram_we,
  inout  wire  [DATA_W-1:0] base_ram_data,
  output logic [ADDR_W-1:0] ext_ram_addr,
  output logic              ext_ram_ce,
  output logic              ext_ram_oe,
  output logic              ext_ram_we,
  inout  wire  [DATA_W-1:0] ext_ram_data
);

  localparam int NUM_LANES = DATA_W / LANE_W;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic                   bank_q, bank_d;
  logic [NUM_LANES-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]      wword_q, wword_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic [DATA_W-1:0]      base_rd, ext_rd, rd_sel, merged;
  phase_e                 phase_d;
  logic                   base_en, ext_en;
  logic                   unused_addr;

  assign unused_addr = ^bus.addr;
  assign rd_sel      = bank_q ? ext_rd : base_rd;

  // Lanes with a byte enable take the new data, the rest keep the word just read.
  always_comb begin
    merged = rd_sel;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (sel_q[i]) merged[i*LANE_W +: LANE_W] = wword_q[i*LANE_W +: LANE_W];
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    bank_d  = bank_q;
    sel_d   = sel_q;
    wword_d = wword_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          waddr_d = bus.addr[ADDR_W+1:2];
          bank_d  = bus.addr[BANK_BIT];
          sel_d   = bus.sel;
          wword_d = bus.wdata;
          if (!bus.we)             state_d = ST_RD;
          else if (bus.sel == '0)  state_d = ST_DONE;
          else if (&bus.sel)       state_d = ST_WR;
          else                     state_d = ST_RMW_RD;
        end
      end
      ST_RD: begin
        rdata_d = rd_sel;
        state_d = ST_DONE;
      end
      ST_RMW_RD: begin
        wword_d = merged;
        state_d = ST_WR;
      end
      ST_WR:      state_d = ST_WR_HOLD;
      ST_WR_HOLD: state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      waddr_q <= '0;
      bank_q  <= 1'b0;
      sel_q   <= '0;
      wword_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      bank_q  <= bank_d;
      sel_q   <= sel_d;
      wword_q <= wword_d;
      rdata_q <= rdata_d;
    end
  end

  // Pin drivers register from next-state values so strobes line up with the
  // state they belong to without any combinational path from the request.
  assign phase_d = state_phase(state_d);
  assign base_en = (phase_d != PH_IDLE) && !bank_d;
  assign ext_en  = (phase_d != PH_IDLE) && bank_d;

  sram_port_drv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_base (
    .clk      (clk),
    .rst      (rst),
    .enable   (base_en),
    .phase    (phase_d),
    .address  (waddr_d),
    .wword    (wword_d),
    .ram_addr (base_ram_addr),
    .ram_ce   (base_ram_ce),
    .ram_oe   (base_ram_oe),
    .ram_we   (base_ram_we),
    .ram_data (base_ram_data),
    .rd_word  (base_rd)
  );

  sram_port_drv #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ext (
    .clk      (clk),
    .rst      (rst),
    .enable   (ext_en),
    .phase    (phase_d),
    .address  (waddr_d),
    .wword    (wword_d),
    .ram_addr (ext_ram_addr),
    .ram_ce   (ext_ram_ce),
    .ram_oe   (ext_ram_oe),
    .ram_we   (ext_ram_we),
    .ram_data (ext_ram_data),
    .rd_word  (ext_rd)
  );

  assign bus.rdata = rdata_q;
  assign bus.ack   = (state_q == ST_DONE);
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-side controller that turns single-word CPU memory requests into cycle-accurate strobe sequences on the two 32-bit asynchronous SRAM banks (base and ext). It sits between the CPU's memory stage/bus arbiter and the board SRAM pins, and the test RAM model in simulation. Partial-word writes are done as read-modify-write because the SRAM has no byte enables.

## Interface
Parameters:
- ADDR_W, 20, SRAM word-address width (`RAMAddrBus`)
- DATA_W, 32, SRAM data width (`RAMBus`)
- BANK_BIT, 22, CPU byte-address bit selecting the bank: 0 = base, 1 = ext

Ports:
- clk  in  1  single clock, all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  request valid (level)
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address; [ADDR_W+1:2] = word address, [BANK_BIT] = bank, others ignored
- sel  in  4  byte enables for writes; sel[i] covers wdata[8i+7:8i]
- wdata  in  32  write data
- rdata  out  32  read data, valid when ack=1
- ack  out  1  one-cycle completion pulse
- busy  out  1  1 in every state except IDLE
- base_ram_addr / ext_ram_addr  out  ADDR_W  word address
- base_ram_ce / ext_ram_ce  out  1  chip enable, active low
- base_ram_oe / ext_ram_oe  out  1  output enable, active low
- base_ram_we / ext_ram_we  out  1  write enable, active low
- base_ram_data / ext_ram_data  inout  DATA_W  tri-stated bus

## Operation
- Accept: in IDLE with req=1, latch we, word address, bank, sel, wdata. Inputs are ignored in every other state. The requester drops req in the ack cycle. If req is still high in the next IDLE cycle, the controller starts a new access.
- States: IDLE, RD, RMW_RD, WR, WR_HOLD, DONE.
- Read: IDLE→RD→DONE. In RD the selected bank has ce=0, oe=0, we=1, and this block does not drive the bus. The bus is sampled into the rdata register at the end of RD. The full word is returned and sel is ignored.
- Full write (sel=4'hF): IDLE→WR→WR_HOLD→DONE.
  - WR: ce=0, oe=1, we=0, bus driven with the data word.
  - WR_HOLD: we=1, ce=0, bus still driven, address held.
- Partial write (sel≠0, ≠F): IDLE→RMW_RD→WR→WR_HOLD→DONE.
  - RMW_RD is the same strobes as RD.
  - The merged word = sel[i] ? wdata byte : read byte, registered at the end of RMW_RD.
- Write with sel=0: IDLE→DONE. No SRAM strobes; ack is still given.
- DONE: ack=1 for one cycle, all strobes inactive, then IDLE.
- Unselected bank and all idle states:
  - ce=oe=we=1, bus Z
  - address holds its last value (0 after reset)
- The bus is driven only in WR and WR_HOLD. Each bank's data pin has its own output-enable.
- addr[1:0] and bits above BANK_BIT are ignored. No misalignment error is raised.

## Timing
- Reset values: state IDLE; rdata=0, ack=0, busy=0; all ce/oe/we=1; both addresses 0; both buses Z.
- Accept at edge 0 sets busy=1 in cycle 1. ack comes in:
  - cycle 2 for a read
  - cycle 3 for a full write
  - cycle 4 for a partial write
  - cycle 1 for sel=0
- Back-to-back requests: next accept is at the end of the IDLE cycle following DONE. Minimum read spacing is 3 cycles.
- All pin outputs are registered (state-decoded from flops). There are no combinational paths from req/addr to the pins.
- rst asserted mid-access: next cycle is IDLE with reset values.
  - A write whose WR cycle coincided with the reset edge has committed.
  - No ack is produced for the aborted access.
- rdata holds its value until the next read or RMW completes. RMW does not update rdata.

## Structure
- Shared package/defines (defines.v): RAMAddrBus, RAMBus, the state encoding constants, the bank-select bit index, and the byte-merge lane width.
- Sub-module `sram_port_drv`, instantiated twice (base, ext):
  - inputs: enable, phase, address, write word
  - drives ce/oe/we, address, and the tri-state buffer for one bank
- FSM, request latch and byte merge stay in the top module.

## Test plan
- Reset held 3 cycles → all ce/oe/we=1, buses Z, ack=0, busy=0, rdata=0.
- Full write addr=0x0000_0010, wdata=0xDEADBEEF, sel=F, then read the same address → base bank word 4 written, ack 3 cycles after accept, rdata=0xDEADBEEF 2 cycles after read accept, ext_ram_ce stays 1.
- Preload ext word 0 = 0x11223344, write addr=0x0040_0000, sel=4'b0101, wdata=0xAABBCCDD → RMW path, ack in cycle 4, stored word 0x11BB33DD.
- Write with sel=0 → ack after 1 cycle, no ce low on either bank, memory unchanged.
- req held high across ack → second identical access starts in the IDLE cycle after DONE. Two acks separated by exactly 3 cycles for reads.
- rst asserted in RMW_RD → next cycle IDLE with all strobes inactive, no ack, memory word unchanged.
